// File: rtl/nonogram_pkg.sv
// rtl/nonogram_pkg.sv - shared constants and queue-state type for the option queue
package nonogram_pkg;

    localparam int OPT_W_DEF = 16;
    localparam int DEPTH_DEF = 256;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SOLVE = 2'd2,
        ST_DONE  = 2'd3
    } queue_state_t;

endpackage

// File: rtl/option_queue_ctrl_if.sv
// rtl/option_queue_ctrl_if.sv - parser/solver handshake bundle for the option queue
interface option_queue_ctrl_if
    import nonogram_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OPT_W = OPT_W_DEF
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             start_load;
    logic             load_valid;
    logic [OPT_W-1:0] load_option;
    logic             load_ready;
    logic             load_done;
    logic             pop;
    logic             push_valid;
    logic [OPT_W-1:0] push_option;
    logic             solved;
    logic             unsolvable;
    logic             started;
    logic [OPT_W-1:0] head_option;
    logic             head_valid;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             overflow;
    logic             underflow;
    logic             proto_err;

    modport master (
        output start_load, load_valid, load_option, load_done,
               pop, push_valid, push_option, solved, unsolvable,
        input  load_ready, started, head_option, head_valid, count,
               busy, overflow, underflow, proto_err
    );

    modport slave (
        input  start_load, load_valid, load_option, load_done,
               pop, push_valid, push_option, solved, unsolvable,
        output load_ready, started, head_option, head_valid, count,
               busy, overflow, underflow, proto_err
    );

endinterface

// File: rtl/option_fifo_ram.sv
// rtl/option_fifo_ram.sv - option storage, one synchronous write port, asynchronous read
module option_fifo_ram #(
    parameter int DEPTH = 256,
    parameter int OPT_W = 16,
    parameter int PTR_W = 8
) (
    input  logic             clk,
    input  logic             we,
    input  logic [PTR_W-1:0] waddr,
    input  logic [OPT_W-1:0] wdata,
    input  logic [PTR_W-1:0] raddr,
    output logic [OPT_W-1:0] rdata
);

    logic [OPT_W-1:0] mem [DEPTH];

    // Write port; contents are not reset, the controller tracks validity.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/option_queue_ctrl.sv
// rtl/option_queue_ctrl.sv - option queue between parser and solver with load/solve FSM
module option_queue_ctrl
    import nonogram_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF,
    parameter int OPT_W = OPT_W_DEF
) (
    input  logic                clk,
    input  logic                rst_n,
    option_queue_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    queue_state_t     state_q, state_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             started_q, started_d;
    logic             overflow_q, overflow_d;
    logic             underflow_q, underflow_d;
    logic             proto_err_q, proto_err_d;

    logic             we;
    logic [OPT_W-1:0] wdata;
    logic             not_full;
    logic             not_empty;
    logic             pop_ok;
    logic             push_ok;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign not_full  = (count_q < CNT_W'(DEPTH));
    assign not_empty = (count_q != '0);

    // State, pointers, count and sticky flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            started_q   <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            started_q   <= started_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            proto_err_q <= proto_err_d;
        end
    end

    // Next state, write arbitration and pointer/count update.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        started_d   = 1'b0;
        overflow_d  = overflow_q;
        underflow_d = underflow_q;
        proto_err_d = proto_err_q;
        we          = 1'b0;
        wdata       = (state_q == ST_SOLVE) ? bus.push_option : bus.load_option;
        pop_ok      = 1'b0;
        push_ok     = 1'b0;

        if (bus.start_load) begin
            // A new puzzle flushes everything, whatever else is requested.
            state_d     = ST_LOAD;
            rd_ptr_d    = '0;
            wr_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
            proto_err_d = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (bus.load_valid) begin
                        if (not_full) begin
                            we       = 1'b1;
                            wr_ptr_d = ptr_inc(wr_ptr_q);
                            count_d  = count_q + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                    if (bus.push_valid) begin
                        proto_err_d = 1'b1;
                    end
                    if (bus.load_done) begin
                        if (not_empty) begin
                            state_d   = ST_SOLVE;
                            started_d = 1'b1;
                        end else begin
                            state_d     = ST_DONE;
                            proto_err_d = 1'b1;
                        end
                    end
                end
                ST_SOLVE: begin
                    pop_ok  = bus.pop && not_empty;
                    // A pop in the same cycle frees the slot the push lands in.
                    push_ok = bus.push_valid && (not_full || pop_ok);
                    if (bus.pop && !not_empty) begin
                        underflow_d = 1'b1;
                    end
                    if (bus.push_valid && !push_ok) begin
                        overflow_d = 1'b1;
                    end
                    if (bus.load_valid) begin
                        proto_err_d = 1'b1;
                    end
                    if (pop_ok) begin
                        rd_ptr_d = ptr_inc(rd_ptr_q);
                    end
                    if (push_ok) begin
                        we       = 1'b1;
                        wr_ptr_d = ptr_inc(wr_ptr_q);
                    end
                    if (push_ok && !pop_ok) begin
                        count_d = count_q + CNT_W'(1);
                    end else if (pop_ok && !push_ok) begin
                        count_d = count_q - CNT_W'(1);
                    end
                    if (bus.solved || bus.unsolvable) begin
                        state_d = ST_DONE;
                    end
                end
                default: begin
                    // IDLE and DONE own no write port.
                    if (bus.load_valid || bus.push_valid) begin
                        proto_err_d = 1'b1;
                    end
                end
            endcase
        end
    end

    option_fifo_ram #(
        .DEPTH (DEPTH),
        .OPT_W (OPT_W),
        .PTR_W (PTR_W)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_q),
        .wdata (wdata),
        .raddr (rd_ptr_q),
        .rdata (bus.head_option)
    );

    assign bus.load_ready = (state_q == ST_LOAD) && not_full;
    assign bus.head_valid = not_empty;
    assign bus.count      = count_q;
    assign bus.busy       = (state_q == ST_LOAD) || (state_q == ST_SOLVE);
    assign bus.started    = started_q;
    assign bus.overflow   = overflow_q;
    assign bus.underflow  = underflow_q;
    assign bus.proto_err  = proto_err_q;

endmodule
